mmio_port_bank: RTL

MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

---
 rtl/mmio_port_bank.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mmio_port_bank.sv
// Bank of memory-mapped 32-bit GPIO ports with synchronised inputs,
// rising-edge flags and an interrupt line.
module mmio_port_bank #(
  parameter int          NUM_PORTS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            busAddress,
  input  logic [31:0]            busWriteData,
  input  logic [3:0]             busByteEnable,
  input  logic                   busWriteEnable,
  input  logic                   busReadEnable,
  output logic [31:0]            busReadData,
  output logic                   busReadValid,
  output logic                   busAddressError,
  input  logic [NUM_PORTS*32-1:0] portInput,
  output logic [NUM_PORTS*32-1:0] portOutput,
  output logic [NUM_PORTS*32-1:0] portDirection,
  output logic                   irq
);

  localparam int W = NUM_PORTS * 32;

  function automatic logic [31:0] swapBytes(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  logic [31:0] outReg  [NUM_PORTS];
  logic [31:0] dirReg  [NUM_PORTS];
  logic [31:0] flagReg [NUM_PORTS];
  logic [31:0] ienReg  [NUM_PORTS];

  logic [W-1:0] syncQ [SYNC_STAGES];
  logic [W-1:0] syncIn;
  logic [W-1:0] prevIn;
  logic [W-1:0] rise;

  logic [3:0]           portSel;
  logic [1:0]           regSel;
  logic                 mapped;
  logic [31:0]          wData;
  logic [31:0]          wMask;
  logic [31:0]          rdVal;
  logic                 irqNext;
  logic [NUM_PORTS-1:0] wrSel;

  assign portSel = busAddress[7:4];
  assign regSel  = busAddress[3:2];
  assign mapped  = (busAddress[31:8] == BASE_ADDR[31:8])
                && (busAddress[1:0] == 2'b00)
                && ({28'd0, portSel} < 32'(NUM_PORTS));

  // Bus lane i lands on register byte 3-i
  assign wData = swapBytes(busWriteData);
  assign wMask = swapBytes({{8{busByteEnable[3]}},
                            {8{busByteEnable[2]}},
                            {8{busByteEnable[1]}},
                            {8{busByteEnable[0]}}});

  assign syncIn = syncQ[SYNC_STAGES-1];
  assign rise   = syncIn & ~prevIn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        syncQ[k] <= '0;
      prevIn <= '0;
    end else begin
      syncQ[0] <= portInput;
      for (int k = 1; k < SYNC_STAGES; k++)
        syncQ[k] <= syncQ[k-1];
      prevIn <= syncIn;
    end
  end

  always_comb begin
    rdVal   = '0;
    irqNext = 1'b0;
    wrSel   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      irqNext  = irqNext | (|(flagReg[p] & ienReg[p]));
      wrSel[p] = busWriteEnable && mapped && (portSel == 4'(p));
      if (mapped && portSel == 4'(p)) begin
        unique case (regSel)
          2'd0: rdVal = (dirReg[p] & outReg[p])
                      | (~dirReg[p] & syncIn[p*32 +: 32]);
          2'd1: rdVal = dirReg[p];
          2'd2: rdVal = flagReg[p];
          2'd3: rdVal = ienReg[p];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        outReg[p]  <= '0;
        dirReg[p]  <= '0;
        flagReg[p] <= '0;
        ienReg[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wrSel[p] && regSel == 2'd0)
          outReg[p] <= (outReg[p] & ~wMask) | (wData & wMask);
        if (wrSel[p] && regSel == 2'd1)
          dirReg[p] <= (dirReg[p] & ~wMask) | (wData & wMask);
        if (wrSel[p] && regSel == 2'd3)
          ienReg[p] <= (ienReg[p] & ~wMask) | (wData & wMask);
        // A fresh edge overrides a same-cycle clear
        flagReg[p] <= (flagReg[p]
                      & ~((wrSel[p] && regSel == 2'd2) ? (wData & wMask) : '0))
                    | rise[p*32 +: 32];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busReadData     <= '0;
      busReadValid    <= 1'b0;
      busAddressError <= 1'b0;
      irq             <= 1'b0;
    end else begin
      busReadData     <= busReadEnable ? swapBytes(rdVal) : '0;
      busReadValid    <= busReadEnable;
      busAddressError <= (busReadEnable | busWriteEnable) & ~mapped;
      irq             <= irqNext;
    end
  end

  always_comb begin
    portOutput    = '0;
    portDirection = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      portOutput[p*32 +: 32]    = outReg[p];
      portDirection[p*32 +: 32] = dirReg[p];
    end
  end

endmodule
